// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - free-running cycle counter, 1 us machine timer and 16-byte MMIO window
//
// Parameters:
//   FMAX_MHz   core clock in MHz; the prescaler divides by this to make a 1 us tick
//   BASE_ADDR  byte base of the 16-byte register window
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cmd_start, cmd_write, addr,     request valid, 1 = write, word-aligned address,
//   wdata                           write data
//   cmd_ready                       high in IDLE, request accepted on cmd_start
//   rdata, rdata_valid              one-cycle response strobe (reads and writes)
//   reg_cycle                       free-running clock count
//   reg_time, reg_mtime             microsecond timer (reg_time mirrors reg_mtime)
//   reg_mtimecmp                    machine timer compare
// Map: +0x0 mtime lo, +0x4 mtime hi, +0x8 mtimecmp lo, +0xC mtimecmp hi.

module timer_counter #(
  parameter int          FMAX_MHz  = 27,
  parameter logic [31:0] BASE_ADDR = 32'hf000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_start,
  input  logic        cmd_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        cmd_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic [63:0] reg_cycle,
  output logic [63:0] reg_time,
  output logic [63:0] reg_mtime,
  output logic [63:0] reg_mtimecmp
);

  localparam int            PW           = (FMAX_MHz > 1) ? $clog2(FMAX_MHz) : 1;
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(FMAX_MHz - 1);

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state_q;
  logic          cmd_ready_q;
  logic          rdata_valid_q;
  logic [31:0]   rdata_q;
  logic [63:0]   cycle_q,    cycle_d;
  logic [PW-1:0] prescale_q, prescale_d;
  logic [63:0]   mtime_q,    mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;

  logic        tick;
  logic        accept;
  logic        in_window;
  logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi;
  logic [31:0] rd_val;

  assign tick      = (prescale_q == PRESCALE_MAX);
  assign accept    = (state_q == IDLE) && cmd_start;
  // Misaligned addresses are treated as unmapped.
  assign in_window = (addr[31:4] == BASE_ADDR[31:4]) && (addr[1:0] == 2'b00);

  assign wr_mtime_lo = accept && cmd_write && in_window && (addr[3:2] == 2'd0);
  assign wr_mtime_hi = accept && cmd_write && in_window && (addr[3:2] == 2'd1);
  assign wr_cmp_lo   = accept && cmd_write && in_window && (addr[3:2] == 2'd2);
  assign wr_cmp_hi   = accept && cmd_write && in_window && (addr[3:2] == 2'd3);

  always_comb begin
    cycle_d    = cycle_q + 64'd1;
    prescale_d = tick ? '0 : prescale_q + 1'b1;

    // A write to either mtime half suppresses that tick entirely: the written
    // half takes wdata and the other half is left as-is, with no carry.
    mtime_d = mtime_q;
    if (wr_mtime_lo) begin
      mtime_d[31:0] = wdata;
    end else if (wr_mtime_hi) begin
      mtime_d[63:32] = wdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    mtimecmp_d = mtimecmp_q;
    if (wr_cmp_lo) begin
      mtimecmp_d[31:0] = wdata;
    end else if (wr_cmp_hi) begin
      mtimecmp_d[63:32] = wdata;
    end
  end

  always_comb begin
    rd_val = 32'h0;
    if (in_window) begin
      case (addr[3:2])
        2'd0:    rd_val = mtime_q[31:0];
        2'd1:    rd_val = mtime_q[63:32];
        2'd2:    rd_val = mtimecmp_q[31:0];
        default: rd_val = mtimecmp_q[63:32];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q    <= 64'd0;
      prescale_q <= '0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hffff_ffff_ffff_ffff;
    end else begin
      cycle_q    <= cycle_d;
      prescale_q <= prescale_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  // Request FSM: RESP lasts exactly one cycle, and cmd_start is not looked at
  // there, so nothing is queued behind an in-flight request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b1;
      rdata_valid_q <= 1'b0;
      rdata_q       <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_start) begin
            state_q       <= RESP;
            cmd_ready_q   <= 1'b0;
            rdata_valid_q <= 1'b1;
            rdata_q       <= cmd_write ? 32'h0 : rd_val;
          end
        end
        default: begin
          state_q       <= IDLE;
          cmd_ready_q   <= 1'b1;
          rdata_valid_q <= 1'b0;
          rdata_q       <= 32'h0;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rdata        = rdata_q;
  assign rdata_valid  = rdata_valid_q;
  assign reg_cycle    = cycle_q;
  assign reg_mtime    = mtime_q;
  assign reg_time     = mtime_q;
  assign reg_mtimecmp = mtimecmp_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - self-checking bench for timer_counter

module tb_timer_counter;

  localparam logic [31:0] BASE = 32'hf000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_start;
  logic        cmd_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        cmd_ready;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic [63:0] reg_cycle;
  logic [63:0] reg_time;
  logic [63:0] reg_mtime;
  logic [63:0] reg_mtimecmp;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [63:0] tb_cyc;

  timer_counter #(.FMAX_MHz(27), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_start    (cmd_start),
    .cmd_write    (cmd_write),
    .addr         (addr),
    .wdata        (wdata),
    .cmd_ready    (cmd_ready),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .reg_cycle    (reg_cycle),
    .reg_time     (reg_time),
    .reg_mtime    (reg_mtime),
    .reg_mtimecmp (reg_mtimecmp)
  );

  always #5 clk = ~clk;

  // Independent cycle model: zero while reset is sampled, +1 per edge otherwise.
  always @(posedge clk) begin
    if (!rst_n) tb_cyc <= 64'd0;
    else        tb_cyc <= tb_cyc + 64'd1;
  end

  // One request: drive, wait for the accept edge, capture the response.
  // ok = strobe present one cycle after accept and cleared (with rdata = 0) a cycle later.
  task automatic bus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] got, output logic ok);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 8) begin
      @(posedge clk); #1; n++;
    end
    cmd_start = 1'b1; cmd_write = wr; addr = a; wdata = d;
    @(posedge clk); #1;
    cmd_start = 1'b0; cmd_write = 1'b0; wdata = 32'h0;
    got = rdata;
    ok  = (rdata_valid === 1'b1);
    @(posedge clk); #1;
    if (rdata_valid !== 1'b0 || rdata !== 32'h0) ok = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_start = 1'b0; cmd_write = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (reg_cycle !== 64'd0 || reg_mtime !== 64'd0 || reg_time !== 64'd0) begin
      errors++; $display("FAIL reset_counters cycle=%h mtime=%h time=%h want 0", reg_cycle, reg_mtime, reg_time);
    end
    checks++;
    if (reg_mtimecmp !== 64'hffff_ffff_ffff_ffff) begin
      errors++; $display("FAIL reset_mtimecmp got=%h want all ones", reg_mtimecmp);
    end
    checks++;
    if (cmd_ready !== 1'b1 || rdata_valid !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL reset_bus ready=%b valid=%b rdata=%h want 1/0/0", cmd_ready, rdata_valid, rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_tick_rate;
    repeat (26) @(posedge clk);
    #1;
    checks++;
    if (reg_cycle !== 64'd26 || reg_mtime !== 64'd0) begin
      errors++; $display("FAIL tick_before cycle=%0d mtime=%0d want 26/0", reg_cycle, reg_mtime);
    end
    @(posedge clk); #1;
    checks++;
    if (reg_mtime !== 64'd1) begin
      errors++; $display("FAIL tick_first mtime=%0d want 1", reg_mtime);
    end
    repeat (243) @(posedge clk);
    #1;
    checks++;
    if (reg_cycle !== 64'd270 || reg_mtime !== 64'd10 || reg_time !== 64'd10) begin
      errors++; $display("FAIL tick_rate cycle=%0d mtime=%0d time=%0d want 270/10/10", reg_cycle, reg_mtime, reg_time);
    end
  endtask

  task automatic test_collision;
    logic [31:0] got, exp;
    logic        ok;
    int          n = 0;
    exp_q.push_back(32'h0);
    bus(1'b1, BASE + 32'h4, 32'h7, got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      errors++; $display("FAIL coll_hi_write rdata=%h ok=%b want %h", got, ok, exp);
    end
    // Next edge is a tick edge when cycle mod 27 = 26 (prescaler shares reset).
    while ((reg_cycle % 27) != 26 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    exp_q.push_back(32'h0);
    bus(1'b1, BASE, 32'h5, got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      errors++; $display("FAIL coll_lo_write rdata=%h ok=%b want %h", got, ok, exp);
    end
    checks++;
    if (reg_mtime !== {32'h7, 32'h5} || reg_time !== {32'h7, 32'h5}) begin
      errors++; $display("FAIL coll_value mtime=%h time=%h want 0000000700000005", reg_mtime, reg_time);
    end
  endtask

  task automatic test_carry;
    logic [31:0] got, exp;
    logic        ok;
    int          n = 0;
    while ((reg_cycle % 27) != 0 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    exp_q.push_back(32'h0);
    bus(1'b1, BASE, 32'hffff_ffff, got, ok);
    exp_q.push_back(32'h0);
    bus(1'b1, BASE + 32'h4, 32'h0, got, ok);
    exp = exp_q.pop_front();
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp || reg_mtime !== 64'h0000_0000_ffff_ffff) begin
      errors++; $display("FAIL carry_setup mtime=%h ok=%b want 00000000ffffffff", reg_mtime, ok);
    end
    n = 0;
    while (reg_mtime === 64'h0000_0000_ffff_ffff && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (reg_mtime !== 64'h1_0000_0000) begin
      errors++; $display("FAIL carry_tick mtime=%h want 0000000100000000", reg_mtime);
    end
    exp_q.push_back(32'h1);
    bus(1'b0, BASE + 32'h4, 32'h0, got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      errors++; $display("FAIL carry_read_hi rdata=%h ok=%b want %h", got, ok, exp);
    end
    exp_q.push_back(32'h0);
    bus(1'b0, BASE, 32'h0, got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      errors++; $display("FAIL carry_read_lo rdata=%h ok=%b want %h", got, ok, exp);
    end
  endtask

  task automatic test_compare;
    logic [31:0] got, exp;
    logic        ok;
    exp_q.push_back(32'h0);
    bus(1'b1, BASE + 32'h8, 32'h0000_1234, got, ok);
    exp_q.push_back(32'h0);
    bus(1'b1, BASE + 32'hC, 32'h0, got, ok);
    exp = exp_q.pop_front();
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp || reg_mtimecmp !== 64'h1234) begin
      errors++; $display("FAIL cmp_write mtimecmp=%h ok=%b want 1234", reg_mtimecmp, ok);
    end
    exp_q.push_back(32'h1234);
    bus(1'b0, BASE + 32'h8, 32'h0, got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      errors++; $display("FAIL cmp_read_lo rdata=%h ok=%b want %h", got, ok, exp);
    end
    exp_q.push_back(32'h0);
    bus(1'b1, BASE + 32'hC, 32'hdead_beef, got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp || reg_mtimecmp !== 64'hdead_beef_0000_1234) begin
      errors++; $display("FAIL cmp_write_hi mtimecmp=%h ok=%b want deadbeef00001234", reg_mtimecmp, ok);
    end
    exp_q.push_back(32'hdead_beef);
    bus(1'b0, BASE + 32'hC, 32'h0, got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      errors++; $display("FAIL cmp_read_hi rdata=%h ok=%b want %h", got, ok, exp);
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] got, exp;
    logic        ok;
    int          pulses = 0;
    exp_q.push_back(32'h0);
    bus(1'b0, BASE + 32'h10, 32'h0, got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      errors++; $display("FAIL unmapped_read rdata=%h ok=%b want %h", got, ok, exp);
    end
    exp_q.push_back(32'h0);
    bus(1'b1, 32'h0000_0008, 32'h5555_aaaa, got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp || reg_mtimecmp !== 64'hdead_beef_0000_1234) begin
      errors++; $display("FAIL unmapped_write ok=%b mtimecmp=%h want deadbeef00001234", ok, reg_mtimecmp);
    end
    // Hold cmd_start across the RESP edge; it must not produce a second response.
    cmd_start = 1'b1; cmd_write = 1'b0; addr = BASE + 32'h10;
    @(posedge clk); #1;
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== 32'h0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL held_first valid=%b rdata=%h ready=%b want 1/0/0", rdata_valid, rdata, cmd_ready);
    end
    @(posedge clk); #1;
    cmd_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rdata_valid === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL held_no_second pulses=%0d want 0", pulses);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got, exp, v;
    logic        ok;
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      exp_q.push_back(32'h0);
      bus(1'b1, BASE + 32'h8, v, got, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) begin
        errors++; $display("FAIL b2b_write[%0d] rdata=%h ok=%b want %h", i, got, ok, exp);
      end
      exp_q.push_back(v);
      bus(1'b0, BASE + 32'h8, 32'h0, got, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) begin
        errors++; $display("FAIL b2b_read[%0d] rdata=%h ok=%b want %h", i, got, ok, exp);
      end
    end
    checks++;
    if (reg_cycle !== tb_cyc) begin
      errors++; $display("FAIL cycle_untouched reg_cycle=%0d want %0d", reg_cycle, tb_cyc);
    end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    cmd_start = 1'b1; cmd_write = 1'b0; addr = BASE + 32'hC;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    checks++;
    if (rdata_valid !== 1'b1) begin
      errors++; $display("FAIL mid_resp valid=%b want 1", rdata_valid);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rdata_valid !== 1'b0 || rdata !== 32'h0 || cmd_ready !== 1'b1 ||
        reg_mtimecmp !== 64'hffff_ffff_ffff_ffff || reg_mtime !== 64'd0 || reg_cycle !== 64'd0) begin
      errors++; $display("FAIL mid_reset valid=%b rdata=%h ready=%b cmp=%h mtime=%h cycle=%h", rdata_valid, rdata, cmd_ready, reg_mtimecmp, reg_mtime, reg_cycle);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rdata_valid === 1'b1 || cmd_ready !== 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || reg_cycle !== 64'd4) begin
      errors++; $display("FAIL mid_release bad_cycles=%0d cycle=%0d want 0/4", pulses, reg_cycle);
    end
  endtask

  initial begin
    test_reset();
    test_tick_rate();
    test_collision();
    test_carry();
    test_compare();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover entries=%0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
